perf_event_counters: RTL
========================

# perf_event_counters

Parametrised hardware performance-monitor block for the pipelined CPU. It counts cycles and per-channel event pulses (IF stall, IF flush, dcache miss, dcache write-back, …) in synthesizable RTL. It stops at a programmable cycle limit and exposes a coherent snapshot of all counters through a registered read port. It sits beside `CPU` at top level; event inputs are tapped from pipeline control signals.

## Interface
- `NUM_CH`, default 4: number of event channels (1..16).
- `CNT_W`, default 32: width of every event counter and of the cycle counter.
- `SEL_W`, default `$clog2(NUM_CH)` (min 1): width of the read select.
- `clk_i  in  1`: single clock; all state updates on the rising edge.
- `rst_i  in  1`: reset, synchronous and active-low.
- `start_i  in  1`: level enable; counting proceeds only while high.
- `event_i  in  NUM_CH`: one event per channel per cycle when bit high.
- `limit_i  in  CNT_W`: cycle limit; 0 means unlimited; sampled on IDLE→RUN.
- `clear_i  in  1`: synchronous clear of counters, flags and FSM to IDLE.
- `snap_req_i  in  1`: snapshot request (pulse).
- `snap_ack_o  out  1`: one-cycle pulse when the snapshot is captured.
- `rd_sel_i  in  SEL_W`: snapshot channel to read.
- `rd_data_o  out  CNT_W`: registered snapshot value of the selected channel.
- `cycle_o  out  CNT_W`: live cycle counter.
- `done_o  out  1`: high in DONE state.
- `ovf_o  out  NUM_CH`: sticky per-channel overflow flags.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when `start_i`=1. `limit_i` is latched into `limit_q` on this transition.
  - In RUN, `cycle_o` and each channel with `event_i[k]`=1 increment by 1 per cycle, only while `start_i`=1. `start_i`=0 pauses counting and holds the state at RUN.
  - RUN→DONE when `limit_q`≠0 and the post-increment cycle count equals `limit_q`. The final cycle's events are counted.
  - DONE holds all counters frozen until `clear_i` or reset.
  - Events in IDLE are not counted.
- `clear_i` has priority over counting and snapshot; it zeroes counters, `ovf_o`, `limit_q`, snapshot registers and `rd_data_o`. Reset does the same.
- Snapshot:
  - `snap_req_i` high in any state copies all counters into shadow registers at that edge. The copied values include that cycle's increment.
  - `snap_ack_o` pulses on the following cycle.
  - A second request while ack is pending re-captures and re-acks; no queuing.
- Read port: `rd_data_o` equals shadow[`rd_sel_i`] registered, so the value is valid one cycle after `rd_sel_i` is applied. `rd_sel_i` ≥ `NUM_CH` returns 0.
- Arithmetic: unsigned, `CNT_W` bits. Overflow behaviour is set by the macro below; the cycle counter always saturates at all-ones and never wraps.

## Timing
- Reset values: `snap_ack_o`=0, `rd_data_o`=0, `cycle_o`=0, `done_o`=0, `ovf_o`=0, FSM=IDLE.
- First count occurs on the edge after the IDLE→RUN edge. The transition edge itself counts nothing.
- `done_o` rises on the same edge that writes `cycle_o`=`limit_q`.
- Snapshot-to-ack latency is 1 cycle. Select-to-data latency is 1 cycle.
- Simultaneous events:
  - `clear_i` + `snap_req_i`: clear wins and no ack is issued.
  - `snap_req_i` on the DONE-entry edge: captures the final values.
  - Reset mid-RUN: everything returns to reset values next edge.

## Configuration
- `PERF_SATURATE_EN` defined: an event counter at all-ones holds at all-ones. `ovf_o[k]` sets on the first event that would exceed all-ones.
- `PERF_SATURATE_EN` undefined: an event counter wraps to 0. `ovf_o[k]` sets on the wrap edge and stays set until clear or reset.

## Structure
- Shared package `perf_pkg`:
  - FSM state typedef (`perf_state_t`: IDLE, RUN, DONE).
  - Default `NUM_CH`/`CNT_W` constants.
  - Channel index constants: `CH_STALL`=0, `CH_FLUSH`=1, `CH_DMISS`=2, `CH_DWB`=3.
- One sub-module, `perf_event_cnt`: a single channel's counter with the increment, saturate/wrap and overflow logic. It is instantiated `NUM_CH` times in a generate loop. The FSM, snapshot and read mux live in the top.

## Test plan
- Limit: `limit_i`=30, `start_i`=1, `event_i[0]` high every 3rd cycle → `done_o` rises with `cycle_o`=30; ch0=10; counters frozen afterwards.
- Snapshot: snapshot at cycle 12 with ch1 high every cycle → `snap_ack_o` at cycle 13; reading sel=1 gives 12 one cycle later while the live count continues.
- Pause: `start_i` low for cycles 5–9 with events held high → counts exclude those 5 cycles; state stays RUN.
- Overflow: `CNT_W`=4, 20 consecutive events on ch2.
  - With the macro, ch2=15 and `ovf_o[2]`=1.
  - Without it, ch2=4 and `ovf_o[2]`=1.
- Priority: `clear_i` and `snap_req_i` on the same edge in DONE → all zero, no ack, IDLE. Reset (`rst_i`=0) mid-RUN → all outputs at reset values next edge.
- Read bounds: `NUM_CH`=3 with sel=3 → `rd_data_o`=0; limit 0 runs 100 cycles with `done_o`=0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared definitions for the performance-monitor block: FSM state type,
// default sizing constants, event channel index assignments and a helper
// for the read-select width.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perf_state_t;

  localparam int PERF_NUM_CH = 4;
  localparam int PERF_CNT_W  = 32;

  localparam int CH_STALL = 0;
  localparam int CH_FLUSH = 1;
  localparam int CH_DMISS = 2;
  localparam int CH_DWB   = 3;

  // A single channel still needs a one-bit select.
  function automatic int perf_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/perf_event_cnt.sv
// One event channel: counts increment pulses and raises a sticky overflow flag.
// PERF_SATURATE_EN defined: the counter sticks at all-ones and the flag sets on
// the first event that would pass all-ones. Undefined: the counter wraps to 0
// and the flag sets on the wrap edge.
// cnt_next_o exposes the post-increment value so a snapshot taken on the same
// edge sees this cycle's event.
module perf_event_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_q;
  logic             ovf_next;

  // Next count and overflow flag for an increment request.
  always_comb begin
    cnt_next = cnt_q;
    ovf_next = ovf_q;
    if (inc_i) begin
`ifdef PERF_SATURATE_EN
      if (cnt_q == '1) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_q + ONE;
      end
`else
      cnt_next = cnt_q + ONE;
      if (cnt_q == '1) begin
        ovf_next = 1'b1;
      end
`endif
    end
  end

  // Count and overflow state; reset and clear both return to zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      ovf_q <= ovf_next;
    end
  end

  assign cnt_next_o = cnt_next;
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/perf_event_counters.sv
// Hardware performance monitor: a saturating cycle counter plus NUM_CH event
// counters, controlled by an IDLE/RUN/DONE FSM with an optional cycle limit.
// A snapshot request copies every channel into shadow registers; the read
// port returns the selected shadow value one cycle later.
// Optional feature macro: PERF_SATURATE_EN (event counters saturate instead
// of wrapping; see perf_event_cnt).
module perf_event_counters
  import perf_pkg::*;
#(
  parameter int NUM_CH = PERF_NUM_CH,
  parameter int CNT_W  = PERF_CNT_W,
  parameter int SEL_W  = perf_sel_w(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [CNT_W-1:0]  limit_i,
  input  logic              clear_i,
  input  logic              snap_req_i,
  output logic              snap_ack_o,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic              done_o,
  output logic [NUM_CH-1:0] ovf_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  perf_state_t      state_q;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] cycle_next;
  logic             done_q;
  logic             count_en;

  logic [CNT_W-1:0] cnt_next [NUM_CH];
  logic [CNT_W-1:0] shadow_q [NUM_CH];
  logic             snap_ack_q;
  logic [CNT_W-1:0] rd_mux;
  logic [CNT_W-1:0] rd_data_q;

  // Counting only happens in RUN with the level enable held high; the cycle
  // counter never wraps.
  assign count_en   = (state_q == RUN) && start_i;
  assign cycle_next = (cycle_q == '1) ? cycle_q : (cycle_q + ONE);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    perf_event_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .inc_i      (count_en && event_i[k]),
      .cnt_next_o (cnt_next[k]),
      .ovf_o      (ovf_o[k])
    );
  end

  // Run-control FSM with cycle counter, limit latch and registered done flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      state_q <= IDLE;
      limit_q <= '0;
      cycle_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            limit_q <= limit_i;
          end
        end
        RUN: begin
          if (start_i) begin
            cycle_q <= cycle_next;
            if ((limit_q != '0) && (cycle_next == limit_q)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot capture of post-increment channel values and one-cycle ack.
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      snap_ack_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      snap_ack_q <= snap_req_i;
      if (snap_req_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
          shadow_q[k] <= cnt_next[k];
        end
      end
    end
  end

  // Select the shadow entry; selects beyond the last channel read as zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd_sel_i == SEL_W'(k)) begin
        rd_mux = shadow_q[k];
      end
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_mux;
    end
  end

  assign snap_ack_o = snap_ack_q;
  assign rd_data_o  = rd_data_q;
  assign cycle_o    = cycle_q;
  assign done_o     = done_q;

endmodule
